// File: rtl/button_input_pkg.sv
// Shared definitions for the debounced button/GPIO input peripheral:
// register word offsets and the bus handshake state type.
package button_input_pkg;

    localparam logic [1:0] BTN_STATE    = 2'd0;
    localparam logic [1:0] BTN_PRESSED  = 2'd1;
    localparam logic [1:0] BTN_RELEASED = 2'd2;
    localparam logic [1:0] BTN_IRQ_MASK = 2'd3;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One input bit: 2-flop synchroniser, optional inversion, and a saturating
// debounce counter that only accepts a level held for DEBOUNCE_CYCLES cycles.
module btn_debounce
    import button_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter logic        INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sync_bit_s;
    logic             accept_s;

    assign sync_bit_s = sync2_q ^ INVERT;
    // accept_s marks the edge on which stable_q takes the new level
    assign accept_s   = (sync_bit_s != stable_q) && (cnt_q == CNT_MAX);

    // Debounce next-state: clear on agreement, accept at terminal count, else count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_bit_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_bit_s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, stable level and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = accept_s & sync_bit_s;
    assign fall_o   = accept_s & ~sync_bit_s;

endmodule

// File: rtl/button_input.sv
// Memory-mapped debounced input block: per-bit debouncers, sticky
// press/release latches, IRQ mask and a one-cycle-acknowledge bus port.
module button_input
    import button_input_pkg::*;
#(
    parameter int unsigned       WIDTH           = 7,
    parameter int unsigned       DEBOUNCE_CYCLES = 1024,
    parameter logic [WIDTH-1:0]  INVERT          = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             irq
);

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] clr_pressed_s;
    logic [WIDTH-1:0] clr_released_s;
    logic [31:0]      rd_word_s;
    logic             unused_wdata_s;

    logic [WIDTH-1:0] pressed_q;
    logic [WIDTH-1:0] pressed_d;
    logic [WIDTH-1:0] released_q;
    logic [WIDTH-1:0] released_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    bus_state_e       state_q;
    bus_state_e       state_d;
    logic             ready_q;
    logic             ready_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             irq_q;
    logic             irq_d;

    assign unused_wdata_s = ^wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT[g])
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .pin_i    (pin_in[g]),
            .stable_o (stable_s[g]),
            .rise_o   (rise_s[g]),
            .fall_o   (fall_s[g])
        );
    end

    // Read multiplexer over the current register values, zero-extended.
    always_comb begin
        rd_word_s = 32'h0;
        case (addr)
            BTN_STATE:    rd_word_s[WIDTH-1:0] = stable_s;
            BTN_PRESSED:  rd_word_s[WIDTH-1:0] = pressed_q;
            BTN_RELEASED: rd_word_s[WIDTH-1:0] = released_q;
            BTN_IRQ_MASK: rd_word_s[WIDTH-1:0] = mask_q;
            default:      rd_word_s = 32'h0;
        endcase
    end

    // Bus FSM, register writes and event latches.
    always_comb begin
        state_d        = state_q;
        ready_d        = 1'b0;
        rdata_d        = 32'h0;
        mask_d         = mask_q;
        clr_pressed_s  = '0;
        clr_released_s = '0;
        case (state_q)
            BUS_IDLE: begin
                if (sel) begin
                    state_d = BUS_ACK;
                    ready_d = 1'b1;
                    if (we) begin
                        case (addr)
                            BTN_PRESSED:  clr_pressed_s  = wdata[WIDTH-1:0];
                            BTN_RELEASED: clr_released_s = wdata[WIDTH-1:0];
                            BTN_IRQ_MASK: mask_d         = wdata[WIDTH-1:0];
                            default:      mask_d         = mask_q;
                        endcase
                    end else begin
                        rdata_d = rd_word_s;
                    end
                end else begin
                    state_d = BUS_IDLE;
                end
            end
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
        // A new event on the same edge as its W1C keeps the bit set
        pressed_d  = (pressed_q  & ~clr_pressed_s)  | rise_s;
        released_d = (released_q & ~clr_released_s) | fall_s;
        irq_d      = |(pressed_q & mask_q);
    end

    // Register state for the bus port, latches and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BUS_IDLE;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            pressed_q  <= '0;
            released_q <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign irq   = irq_q;

endmodule

// File: doc/button_input.md
# button_input

Memory-mapped debounced input peripheral for the attosoc on ULX3S: the input-side counterpart to the LED/GPIO output path. Takes raw button/GPIO pins, which are asynchronous to `clk`. Synchronises and debounces each bit, latches press/release events, and exposes them to picorv32 through a small register window plus a level interrupt. Instantiated inside the SoC next to the LED register; pins enter through input `TRELLIS_IO` buffers at the top level.

## Interface

Parameters:
- `WIDTH`, 7: number of input bits.
- `DEBOUNCE_CYCLES`, 1024: consecutive cycles a synchronised bit must differ from its stable value before it is accepted. Range 2..65535.
- `INVERT`, `{WIDTH{1'b0}}`: per-bit mask. A set bit inverts that pin after synchronisation, for active-low buttons.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pin_in`  in  WIDTH  raw pins, asynchronous.
- `sel`  in  1  bus access request; held high until `ready`.
- `we`  in  1  write when high, read when low; qualified by `sel`.
- `addr`  in  2  word address: 0 STATE, 1 PRESSED, 2 RELEASED, 3 IRQ_MASK.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, zero-extended; valid only while `ready` is high, 0 otherwise.
- `ready`  out  1  one-cycle access acknowledge.
- `irq`  out  1  `|(PRESSED & IRQ_MASK)`, registered.

## Operation

- **Synchroniser:** each bit goes through a 2-flop synchroniser, then XOR with `INVERT`, giving `s[i]`.
- **Debouncer (per bit):**
  - State is `stable[i]` plus a counter of `$clog2(DEBOUNCE_CYCLES)` bits.
  - If `s == stable`: the counter clears.
  - Otherwise, if `counter == DEBOUNCE_CYCLES-1`: `stable <= s` and the counter clears.
  - Otherwise: the counter increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` never reaches `stable`. The counter cannot wrap.
- **Event latches:**
  - On the edge where `stable[i]` goes 0→1, `PRESSED[i]` sets.
  - On the edge where `stable[i]` goes 1→0, `RELEASED[i]` sets.
  - Both are sticky.
- **Registers:**
  - STATE: read-only, `stable`. Writes are ignored.
  - PRESSED and RELEASED: read, or write-1-to-clear on `wdata[WIDTH-1:0]`.
  - IRQ_MASK: read/write `wdata[WIDTH-1:0]`.
  - Bits `[31:WIDTH]` read 0.
- **Simultaneous W1C and new event on the same bit, same edge:** set wins, so the bit stays 1.
- **Bus FSM:** IDLE → ACK → IDLE.
  - In IDLE with `sel=1`: go to ACK. The write, or the capture of read data, happens on this edge.
  - ACK asserts `ready` for exactly one cycle, then always returns to IDLE, whatever the state of `sel`.
  - A `sel` still high in the cycle after ACK starts a new access.
  - The write side effect occurs once per access.
- **Reset:** clears everything:
  - synchroniser flops, `stable`, and counters;
  - PRESSED, RELEASED, and IRQ_MASK;
  - `irq`, `ready`, and `rdata`;
  - FSM to IDLE.
- **Reset mid-access:** the access is dropped with no `ready`, and the bus master re-issues it.

## Timing

- Pin change to `s`: 2 cycles. An additional cycle is added if the change lands near a clock edge (metastability).
- `s` change to `stable`: `DEBOUNCE_CYCLES` cycles of continuous difference. Pin to STATE is 2+`DEBOUNCE_CYCLES` cycles nominal.
- PRESSED/RELEASED update on the same edge as `stable`. `irq` follows one cycle later.
- Access latency: `sel` at cycle N → `ready`/`rdata` at cycle N+1.
  - Read data reflects register values sampled at edge N.
  - Writes take effect at edge N, so `irq` updates at N+2.
- The `sel` input is synchronous to `clk`; no other handshake exists.

## Structure

- **Package `button_input_pkg`:**
  - register word-offset constants `BTN_STATE`=0, `BTN_PRESSED`=1, `BTN_RELEASED`=2, `BTN_IRQ_MASK`=3;
  - bus FSM state enum.
- **Sub-module `btn_debounce`:** a single bit containing synchroniser, invert, counter, and `stable` output, with parameter `DEBOUNCE_CYCLES`. It is generated `WIDTH` times.
- **Top:** event latches, registers, bus FSM, and `irq`.

## Test plan

All scenarios use `WIDTH`=7 and `DEBOUNCE_CYCLES`=4.

1. **Reset:** hold `rst` 3 cycles with `pin_in`=7'h7F → `rdata`=0, `ready`=0, `irq`=0. Then read STATE → 0 until 6 cycles after release.
2. **Glitch:** drive `pin_in[0]` high for 3 cycles, then low → STATE and PRESSED stay 0. A 4+ cycle high pulse → STATE[0]=1 exactly 6 cycles after the pin rises, and PRESSED=1.
3. **Interrupt:**
   - write IRQ_MASK=7'h01, then press bit 0 → `irq`=1 one cycle after PRESSED sets;
   - write 1 to PRESSED → `irq`=0 two cycles after `sel`;
   - RELEASED[0] sets after the pin falls and stays set.
4. **Collision:** a W1C on PRESSED[2] issued on the same edge as a new rising `stable[2]` → PRESSED[2] reads 1.
5. **Invert and bus:**
   - with `INVERT`=7'h02 and pins 0 → STATE reads 32'h2;
   - `ready` pulses one cycle per access with `sel` held 4 cycles, giving 2 accesses;
   - a write to STATE has no effect.
6. **Reset mid-access:** assert `rst` in the ACK cycle → `ready` is 0 and the registers clear.
